// File: rtl/bank_pkg.sv
// Shared widths, default credit parameters and the balance clamp
// used by the per-requester credit bank.
package bank_pkg;

   localparam int BID_W = 4;
   localparam int BAL_W = 10;

   localparam int DEF_INIT_BALANCE  = 100;
   localparam int DEF_MAX_BALANCE   = 1023;
   localparam int DEF_REFILL_AMOUNT = 1;
   localparam int DEF_REFILL_PERIOD = 4;

   typedef logic signed [BAL_W+1:0] bal_wide_t;

   function automatic logic [BAL_W-1:0] clamp_bal(
      input bal_wide_t        v,
      input logic [BAL_W-1:0] max_bal
   );
      logic [BAL_W-1:0] r;
      if (v < 0)
         r = '0;
      else if (v > $signed({2'b00, max_bal}))
         r = max_bal;
      else
         r = v[BAL_W-1:0];
      return r;
   endfunction

endpackage

// File: rtl/bank_refill_timer.sv
// Free-running refill interval timer; tick is high while the
// counter sits on its last value.
module bank_refill_timer #(
   parameter int REFILL_PERIOD = 4
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(REFILL_PERIOD - 1);

   logic [CW-1:0] r_cnt;
   logic          w_last;

   assign w_last = (r_cnt == LAST);
   assign tick   = w_last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_cnt <= '0;
      else if (w_last)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/bank.sv
// Credit account for one requester: debited by granted bids,
// topped up by the refill timer, clamped to [0, MAX_BALANCE].
module bank
   import bank_pkg::*;
#(
   parameter int INIT_BALANCE  = DEF_INIT_BALANCE,
   parameter int MAX_BALANCE   = DEF_MAX_BALANCE,
   parameter int REFILL_AMOUNT = DEF_REFILL_AMOUNT,
   parameter int REFILL_PERIOD = DEF_REFILL_PERIOD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [BID_W-1:0] bid,
   input  logic             grant,
   output logic [BAL_W-1:0] balance
);

   localparam logic [BAL_W-1:0] INIT_V = BAL_W'(INIT_BALANCE);
   localparam logic [BAL_W-1:0] MAX_V  = BAL_W'(MAX_BALANCE);
   localparam bal_wide_t        REF_V  = (BAL_W+2)'(REFILL_AMOUNT);

   logic             w_tick;
   bal_wide_t        w_debit;
   bal_wide_t        w_credit;
   bal_wide_t        w_sum;
   logic [BAL_W-1:0] r_bal;

   bank_refill_timer #(
      .REFILL_PERIOD(REFILL_PERIOD)
   ) u_timer (
      .clk (clk),
      .rst (rst),
      .tick(w_tick)
   );

   // Widen unsigned operands with zeros so the sum can go negative.
   always_comb begin
      w_debit  = '0;
      w_credit = '0;
      if (grant)
         w_debit = $signed({{(BAL_W+2-BID_W){1'b0}}, bid});
      if (w_tick)
         w_credit = REF_V;
      w_sum = $signed({2'b00, r_bal}) - w_debit + w_credit;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_bal <= INIT_V;
      else
         r_bal <= clamp_bal(w_sum, MAX_V);
   end

   assign balance = r_bal;

endmodule

// File: tb/tb_bank.sv
// Randomized and directed checks of the credit bank against a
// cycle-count based reference model.
module tb_bank;
   import bank_pkg::*;

   logic             clk;
   logic             rst;
   logic [BID_W-1:0] bid;
   logic             grant;
   logic [BAL_W-1:0] bal_lo;
   logic [BAL_W-1:0] bal_hi;

   int n_chk;
   int n_fail;
   int m_lo;
   int m_hi;
   int m_n;

   bank u_lo (
      .clk    (clk),
      .rst    (rst),
      .bid    (bid),
      .grant  (grant),
      .balance(bal_lo)
   );

   bank #(
      .INIT_BALANCE(1022)
   ) u_hi (
      .clk    (clk),
      .rst    (rst),
      .bid    (bid),
      .grant  (grant),
      .balance(bal_hi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int nxt(input int b, input bit g,
                              input int d, input bit tk);
      int v;
      v = b - (g ? d : 0) + (tk ? 1 : 0);
      if (v < 0) v = 0;
      if (v > 1023) v = 1023;
      return v;
   endfunction

   function automatic bit next_is_tick();
      return ((m_n + 1) % 4) == 0;
   endfunction

   // Called at a negedge; returns at the following negedge.
   task automatic step(input bit g, input int d);
      bit tk;
      grant = g;
      bid   = BID_W'(d);
      @(posedge clk);
      m_n++;
      tk   = (m_n % 4) == 0;
      m_lo = nxt(m_lo, g, d, tk);
      m_hi = nxt(m_hi, g, d, tk);
      #1;
      chk("lo_model", int'(bal_lo), m_lo);
      chk("hi_model", int'(bal_hi), m_hi);
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b0;
      #1;
      chk("rst_lo", int'(bal_lo), 100);
      chk("rst_hi", int'(bal_hi), 1022);
      @(negedge clk);
      rst  = 1'b1;
      m_lo = 100;
      m_hi = 1022;
      m_n  = 0;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst    = 1'b0;
      grant  = 1'b0;
      bid    = '0;
      m_lo   = 100;
      m_hi   = 1022;
      m_n    = 0;
      repeat (2) @(negedge clk);
      do_reset();

      // idle refill sequence and ceiling
      begin
         int exp_lo[8] = '{100, 100, 100, 101, 101, 101, 101, 102};
         for (int i = 0; i < 8; i++) begin
            step(0, 0);
            chk("idle_lo", int'(bal_lo), exp_lo[i]);
         end
      end
      chk("sat_hi", int'(bal_hi), 1023);
      for (int i = 0; i < 3; i++) step(0, 0);
      step(1, 1);
      chk("sat_grant", int'(bal_hi), 1023);

      // single debit at a non-tick edge
      do_reset();
      step(1, 5);
      chk("debit5", int'(bal_lo), 95);
      step(0, 0);
      step(0, 0);
      chk("hold95", int'(bal_lo), 95);
      step(0, 0);
      chk("tick96", int'(bal_lo), 96);

      // debit and refill on the same edge
      do_reset();
      for (int i = 0; i < 3; i++) step(0, 0);
      step(1, 4);
      chk("tick_debit", int'(bal_lo), 97);

      // drain to 3, then overdraw
      begin
         int guard;
         int d;
         guard = 0;
         while (!(m_lo == 3 && !next_is_tick()) && guard < 200) begin
            d = m_lo - 3 + (next_is_tick() ? 1 : 0);
            if (d > 15) d = 15;
            if (d < 0) d = 0;
            step(d > 0, d);
            guard++;
         end
         chk("reach3", int'(bal_lo), 3);
      end
      step(1, 9);
      chk("floor", int'(bal_lo), 0);
      if (!next_is_tick()) begin
         step(1, 9);
         chk("floor_again", int'(bal_lo), 0);
      end
      while (!next_is_tick()) step(0, 0);
      step(0, 0);
      chk("floor_tick", int'(bal_lo), 1);

      // random traffic
      for (int i = 0; i < 400; i++)
         step(($urandom % 3) == 0, int'($urandom % 16));

      // async reset between edges, then timer restart
      @(posedge clk);
      do_reset();
      for (int i = 0; i < 3; i++) step(0, 0);
      chk("post_rst3", int'(bal_lo), 100);
      step(0, 0);
      chk("post_rst4", int'(bal_lo), 101);

      for (int i = 0; i < 100; i++)
         step(($urandom % 2) == 0, int'($urandom % 16));

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
